// File: rtl/conv_window_buffer.sv
// Streaming KxK sliding-window generator: K-1 line buffers feed a KxK shift window,
// presented through a single valid/ready output stage with a (row, col) element tap.
module conv_window_buffer #(
    parameter int DW    = 16,
    parameter int K     = 7,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int IDX_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW-1:0]         in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW*K*K-1:0]     out_window,
    input  logic [IDX_W-1:0]      sel_row,
    input  logic [IDX_W-1:0]      sel_col,
    output logic [DW-1:0]         sel_data,
    output logic                  frame_done
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(K - 1);
    localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(K - 1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [CW-1:0] r_col_cnt;
    logic [RW-1:0] r_row_cnt;
    logic [0:0]    r_state;
    logic          r_out_valid;
    logic          r_frame_done;

    logic [DW-1:0] r_win    [K][K];
    logic [DW-1:0] r_lb_mem [K-1][IMG_W];
    logic [DW-1:0] r_lb_q   [K-1];

    logic [DW-1:0] w_col_new [K];
    logic [DW-1:0] w_lb_wr   [K-1];

    logic          w_accept;
    logic          w_push;
    logic          w_col_wrap;
    logic          w_frame_end;
    logic          w_complete;
    logic [CW-1:0] w_col_next;
    logic [RW-1:0] w_row_next;
    logic [CW-1:0] w_rd_addr;
    logic [0:0]    w_state_next;

    assign in_ready    = !r_out_valid || out_ready;
    assign w_accept    = in_valid && in_ready;
    // clear wins over a same-cycle acceptance, so the pixel never reaches the buffers
    assign w_push      = w_accept && !clear;
    assign w_col_wrap  = (r_col_cnt == COL_LAST);
    assign w_frame_end = w_col_wrap && (r_row_cnt == ROW_LAST);
    assign w_complete  = (r_state == ST_RUN) && (r_col_cnt >= COL_FIRST_WIN);

    assign out_valid  = r_out_valid;
    assign frame_done = r_frame_done;

    always_comb begin
        w_col_next = w_col_wrap ? '0 : r_col_cnt + CW'(1);
        w_row_next = r_row_cnt;
        if (w_col_wrap) begin
            w_row_next = w_frame_end ? '0 : r_row_cnt + RW'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FILL: if (w_row_next == ROW_FIRST_WIN) w_state_next = ST_RUN;
            ST_RUN:  if (w_frame_end)                 w_state_next = ST_FILL;
            default:                                  w_state_next = ST_FILL;
        endcase
    end

    // The line-buffer read is registered, so the address is the column the next
    // accepted pixel will land on; unwritten columns keep their data across stalls.
    always_comb begin
        w_rd_addr = r_col_cnt;
        if (clear) begin
            w_rd_addr = '0;
        end else if (w_accept) begin
            w_rd_addr = w_col_next;
        end
    end

    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            w_col_new[r] = r_lb_q[r];
        end
        w_col_new[K-1] = in_data;
    end

    // Each row's pixel moves one buffer up; the top buffer takes the incoming pixel.
    always_comb begin
        for (int r = 0; r < K - 2; r++) begin
            w_lb_wr[r] = r_lb_q[r+1];
        end
        w_lb_wr[K-2] = in_data;
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < K - 1; r++) begin
            if (w_push) begin
                r_lb_mem[r][r_col_cnt] <= w_lb_wr[r];
            end
            r_lb_q[r] <= r_lb_mem[r][w_rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (w_push) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
                r_win[r][K-1] <= w_col_new[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_cnt    <= '0;
            r_row_cnt    <= '0;
            r_state      <= ST_FILL;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (clear) begin
            r_col_cnt    <= '0;
            r_row_cnt    <= '0;
            r_state      <= ST_FILL;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_accept) begin
                r_col_cnt    <= w_col_next;
                r_row_cnt    <= w_row_next;
                r_state      <= w_state_next;
                r_out_valid  <= w_complete;
                r_frame_done <= w_complete && w_frame_end;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                if (sel_row == IDX_W'(r) && sel_col == IDX_W'(c)) begin
                    sel_data = r_win[r][c];
                end
            end
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < K; gi++) begin : g_row
            for (gj = 0; gj < K; gj++) begin : g_col
                assign out_window[(gi*K+gj)*DW +: DW] = r_win[gi][gj];
            end
        end
    endgenerate

endmodule

// File: tb/tb_conv_window_buffer.sv
// Bench for conv_window_buffer (K=3, 8x8 image): random handshakes checked against
// an expected-window list built directly from the stored image frames.
module tb_conv_window_buffer;
    localparam int DW       = 16;
    localparam int K        = 3;
    localparam int W        = 8;
    localparam int H        = 8;
    localparam int IDX_W    = 3;
    localparam int WIN_BITS = DW * K * K;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                clear = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [DW-1:0]       in_data = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [WIN_BITS-1:0] out_window;
    logic [IDX_W-1:0]    sel_row = '0;
    logic [IDX_W-1:0]    sel_col = '0;
    logic [DW-1:0]       sel_data;
    logic                frame_done;

    always #5 clk = ~clk;

    conv_window_buffer #(
        .DW(DW), .K(K), .IMG_W(W), .IMG_H(H), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_window(out_window),
        .sel_row(sel_row), .sel_col(sel_col), .sel_data(sel_data),
        .frame_done(frame_done)
    );

    typedef struct {
        logic [WIN_BITS-1:0] win;
        bit                  last;
    } win_t;

    int            checks = 0;
    int            failures = 0;
    int            n_win;
    int            n_fd;
    win_t          exp_q[$];
    logic [DW-1:0] img [2][H][W];

    function automatic void fill_images(input int mode);
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    img[f][r][c] = (mode == 0) ? DW'(f * 100 + r * W + c) : DW'($urandom);
    endfunction

    // Every valid-padding window of each frame, in raster order of its top-left corner.
    function automatic void build_expected(input int nframes);
        win_t e;
        exp_q.delete();
        for (int f = 0; f < nframes; f++)
            for (int r0 = 0; r0 <= H - K; r0++)
                for (int c0 = 0; c0 <= W - K; c0++) begin
                    e.win = '0;
                    for (int r = 0; r < K; r++)
                        for (int c = 0; c < K; c++)
                            e.win[(r*K+c)*DW +: DW] = img[f][r0+r][c0+c];
                    e.last = (r0 == H - K) && (c0 == W - K);
                    exp_q.push_back(e);
                end
    endfunction

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic run_stream(input int nframes, input int in_gap_pct, input int rdy_gap_pct,
                              input int stall_idx, input int clear_after, input string tag);
        int pix, total, hold, consumed, cyc, pr, pc;
        bit exp_valid, prev_stall, stalled_done, cleared, clr, first, fd_exp, acc;
        logic [WIN_BITS-1:0] held_win;
        build_expected(nframes);
        pix = 0; total = nframes * H * W; consumed = 0; n_win = 0; n_fd = 0; hold = 0;
        exp_valid = 0; prev_stall = 0; stalled_done = 0; cleared = 0; cyc = 0;
        held_win = '0; pr = 0; pc = 0;
        while ((pix < total || exp_valid) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (out_valid !== exp_valid) begin
                failures++;
                $display("FAIL %s out_valid cyc=%0d got=%b want=%b", tag, cyc, out_valid, exp_valid);
            end
            if (out_valid === 1'b1 && prev_stall) begin
                checks++;
                if (out_window !== held_win) begin
                    failures++;
                    $display("FAIL %s held_window cyc=%0d got=%h want=%h", tag, cyc, out_window, held_win);
                end
            end
            first  = (out_valid === 1'b1) && !prev_stall;
            fd_exp = first && exp_q.size() > 0 && exp_q[0].last;
            checks++;
            if (frame_done !== fd_exp) begin
                failures++;
                $display("FAIL %s frame_done cyc=%0d got=%b want=%b", tag, cyc, frame_done, fd_exp);
            end
            if (frame_done === 1'b1) n_fd++;

            clr = (clear_after >= 0) && !cleared && (pix == clear_after);
            if (hold > 0) begin
                out_ready = 1'b0; hold--;
            end else if (out_valid === 1'b1 && consumed == stall_idx && !stalled_done && !clr) begin
                out_ready = 1'b0; hold = 4; stalled_done = 1;
            end else begin
                out_ready = clr ? 1'b1 : ($urandom_range(0, 99) >= rdy_gap_pct);
            end
            in_valid = (pix < total) && (clr || $urandom_range(0, 99) >= in_gap_pct);
            if (pix < total) begin
                pr = (pix % (H * W)) / W;
                pc = pix % W;
                in_data = img[pix / (H * W)][pr][pc];
            end else begin
                in_data = DW'($urandom);
            end
            clear = clr;
            #1;
            checks++;
            if (in_ready !== (!exp_valid || out_ready)) begin
                failures++;
                $display("FAIL %s in_ready cyc=%0d got=%b want=%b", tag, cyc, in_ready, !exp_valid || out_ready);
            end
            acc = in_valid && (!exp_valid || out_ready);

            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s extra_window cyc=%0d got=%h want=none", tag, cyc, out_window);
                end else begin
                    if (out_window !== exp_q[0].win) begin
                        failures++;
                        $display("FAIL %s window#%0d got=%h want=%h", tag, n_win, out_window, exp_q[0].win);
                    end
                    void'(exp_q.pop_front());
                end
                consumed++; n_win++;
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            held_win   = out_window;

            if (clr) begin
                exp_valid = 0; pix = 0; cleared = 1; n_win = 0; consumed = 0; prev_stall = 0;
                build_expected(nframes);
            end else if (acc) begin
                exp_valid = (pr >= K - 1) && (pc >= K - 1);
                pix++;
            end else if (out_ready) begin
                exp_valid = 0;
            end
        end
        if (cyc >= 20000) begin
            failures++;
            $display("FAIL %s timeout got=%0d cycles want=<20000", tag, cyc);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset();
        fill_images(0);
        for (int p = 0; p < 20; p++) begin
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b1; in_data = img[0][p / W][p % W];
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL reset_pre out_valid got=%b want=1", out_valid);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset out_valid got=%b want=0", out_valid); end
        checks++;
        if (frame_done !== 1'b0) begin failures++; $display("FAIL reset frame_done got=%b want=0", frame_done); end
        checks++;
        if (out_window !== '0) begin failures++; $display("FAIL reset out_window got=%h want=0", out_window); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset in_ready got=%b want=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_frame();
        fill_images(0);
        do_clear();
        run_stream(1, 0, 0, -1, -1, "single");
        checks++;
        if (n_win != 36) begin failures++; $display("FAIL single win_count got=%0d want=36", n_win); end
        checks++;
        if (n_fd != 1) begin failures++; $display("FAIL single frame_done_count got=%0d want=1", n_fd); end
    endtask

    task automatic test_backpressure();
        fill_images(0);
        do_clear();
        run_stream(1, 0, 0, 5, -1, "backpressure");
        checks++;
        if (n_win != 36 || exp_q.size() != 0) begin
            failures++; $display("FAIL backpressure win_count got=%0d left=%0d want=36 left=0", n_win, exp_q.size());
        end
    endtask

    task automatic test_selector();
        int r, c;
        logic [DW-1:0] want;
        fill_images(0);
        do_clear();
        for (int p = 0; p <= 20; p++) begin
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b1; in_data = img[0][p / W][p % W];
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL selector out_valid got=%b want=1", out_valid); end
        sel_row = 3'd1; sel_col = 3'd2; #1;
        checks++;
        if (sel_data !== 16'd12) begin failures++; $display("FAIL selector (1,2) got=%0d want=12", sel_data); end
        sel_col = 3'd3; #1;
        checks++;
        if (sel_data !== 16'd0) begin failures++; $display("FAIL selector (1,3) got=%0d want=0", sel_data); end
        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(0, 7); c = $urandom_range(0, 7);
            sel_row = IDX_W'(r); sel_col = IDX_W'(c); #1;
            want = (r < K && c < K) ? img[0][r][2 + c] : '0;
            checks++;
            if (sel_data !== want) begin
                failures++; $display("FAIL selector (%0d,%0d) got=%0d want=%0d", r, c, sel_data, want);
            end
        end
        do_clear();
    endtask

    task automatic test_back_to_back();
        fill_images(0);
        do_clear();
        run_stream(2, 0, 0, -1, -1, "b2b");
        checks++;
        if (n_win != 72) begin failures++; $display("FAIL b2b win_count got=%0d want=72", n_win); end
        checks++;
        if (n_fd != 2) begin failures++; $display("FAIL b2b frame_done_count got=%0d want=2", n_fd); end
    endtask

    task automatic test_clear();
        fill_images(0);
        do_clear();
        run_stream(1, 0, 0, -1, 20, "clear");
        checks++;
        if (n_win != 36) begin failures++; $display("FAIL clear win_count got=%0d want=36", n_win); end
        checks++;
        if (n_fd != 1) begin failures++; $display("FAIL clear frame_done_count got=%0d want=1", n_fd); end
    endtask

    task automatic test_random();
        fill_images(1);
        do_clear();
        run_stream(2, 30, 30, 10, -1, "random");
        checks++;
        if (n_win != 72) begin failures++; $display("FAIL random win_count got=%0d want=72", n_win); end
        checks++;
        if (n_fd != 2) begin failures++; $display("FAIL random frame_done_count got=%0d want=2", n_fd); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_selector();
        test_back_to_back();
        test_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_window_buffer.md
Name: conv_window_buffer

Overview:
- Streaming KxK sliding-window generator for the CNN datapath.
- Accepts raster-order pixels and buffers K-1 image rows internally. Emits every fully-populated KxK window (valid padding) as a flat bus over a valid/ready handshake.
- Also provides a built-in (row, col) element selector on the emitted window.
- Sits between the pixel source and the convolution MAC array.

Parameters:
- DW, 16, pixel/element width in bits.
- K, 7, window side length (K >= 2).
- IMG_W, 28, image width in pixels (IMG_W >= K).
- IMG_H, 28, image height in pixels (IMG_H >= K).
- IDX_W, 3, width of selector indices (2^IDX_W >= K).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; one clock, asynchronous assert, active-low.
- clear  input  1  synchronous frame restart.
- in_valid  input  1  pixel valid.
- in_ready  output  1  pixel accepted when in_valid && in_ready.
- in_data  input  DW  pixel value.
- out_valid  output  1  window valid.
- out_ready  input  1  consumer ready.
- out_window  output  DW*K*K  flat window; element (r,c) occupies bits [(r*K+c+1)*DW-1 : (r*K+c)*DW].
- sel_row  input  IDX_W  selector row index.
- sel_col  input  IDX_W  selector column index.
- sel_data  output  DW  element (sel_row, sel_col) of out_window.
- frame_done  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (rst_n=0, async): out_valid=0, out_window=0, frame_done=0, col/row counters=0, state=FILL. Line-buffer contents are don't-care.
- in_ready = !out_valid || out_ready. Combinational, single output stage, no skid. in_ready=1 out of reset.
- Window orientation:
  - r=0 is the oldest (topmost) row; r=K-1 is the current row.
  - c=0 is the leftmost (oldest) column; c=K-1 is the pixel just accepted.
- Per accepted pixel:
  - Shift the window columns left by one.
  - New right column = line-buffer outputs for rows 0..K-2 plus in_data at row K-1.
  - Write each row's pixel down one line buffer.
  - Advance col_cnt; on col_cnt=IMG_W-1, wrap to 0 and increment row_cnt.
- Window completion: the accepted pixel at (row,col) completes a window iff row >= K-1 and col >= K-1.
- Output register:
  - Latency 1: out_valid and out_window update on the clock edge that accepts the completing pixel.
  - If the pixel does not complete a window and out_ready=1 (or out_valid=0), out_valid goes 0.
  - While out_valid && !out_ready: out_window is held stable and no pixel is accepted.
- Window count per frame: (IMG_H-K+1)*(IMG_W-K+1).
- State machine:
  - FILL: row_cnt < K-1; no windows emitted.
  - RUN: rows K-1..IMG_H-1.
  - RUN -> FILL on acceptance of pixel (IMG_H-1, IMG_W-1); both counters wrap to 0.
  - FILL -> RUN when row_cnt reaches K-1.
- frame_done: asserted for exactly one cycle, coincident with the first cycle out_valid presents the frame's last window.
- Back-to-back frames are supported without gaps. Columns carried over from the prior frame never appear in an emitted window, because of the col >= K-1 rule.
- clear: synchronous.
  - Counters -> 0, state -> FILL, out_valid -> 0, frame_done -> 0.
  - Any pending window is dropped.
  - clear overrides a simultaneous pixel acceptance; that pixel is discarded.
- Reset mid-frame behaves as clear, but asynchronously.
- Selector: sel_data is combinational from out_window. It returns 0 when sel_row >= K or sel_col >= K. It is valid whenever out_valid=1.
- All arithmetic is unsigned. Counters are sized clog2(IMG_W) and clog2(IMG_H).

Test Plan:
- Reset, with rst_n low asserted mid-cycle: out_valid=0, frame_done=0, out_window=0, in_ready=1 immediately (async), no clock required.
- K=3, IMG_W=IMG_H=8; pixel=row*8+col streamed with out_ready=1:
  - First out_valid one cycle after pixel 18 is accepted, with element (0,0)=0, (1,1)=9, (2,2)=18.
  - Exactly 36 windows; last window has (2,2)=63.
  - frame_done pulses once, with the last window.
- Backpressure, same config: drop out_ready for 5 cycles while out_valid=1.
  - in_ready=0 throughout; out_window unchanged.
  - On release, the next window follows with no pixel lost (window sequence identical to the unstalled run).
- Selector, K=3: window with (1,2)=12, sel_row=1, sel_col=2 -> sel_data=12; sel_col=3 -> sel_data=0.
- Two consecutive frames, the second at pixel+100:
  - First window of frame 2 appears one cycle after pixel (2,2) of frame 2, with (0,0)=100 and no frame-1 data.
  - 72 total windows, two frame_done pulses.
- clear asserted after 20 pixels while in_valid=1 and out_valid=1:
  - Next cycle out_valid=0.
  - Restarted frame produces 36 windows identical to the clean run.
